cu_edge_data_write_control: RTL and testbench

Write-side counterpart of the compute unit's edge-data read path. Accepts one data element per cycle (vertex/edge id, cu_id, value), computes its byte address in the target array, and builds a CAPI partial-line write: one command-buffer line plus two half-cacheline write-data lines with the element placed at its cacheline slot. It sits between the CU datapath and the write command/data buffers, and honours their almost-full back-pressure through an internal FIFO.

---
 rtl/cu_edge_data_write_control_pkg.sv | 58 +++++
 rtl/cu_edge_data_write_control_fifo.sv | 55 +++++
 rtl/cu_edge_data_write_control.sv | 177 +++++++++++++++++
 tb/tb_cu_edge_data_write_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_edge_data_write_control_pkg.sv
// Shared types, sizes and helpers for the CU edge-data write path.
package cu_edge_data_write_control_pkg;

  localparam int DATA_SIZE_WRITE               = 4;
  localparam int DATA_SIZE_WRITE_BITS          = 32;
  localparam int DATA_SIZE_WRITE_LOG2          = 2;
  localparam int EDGE_SIZE_BITS                = 32;
  localparam int CU_ID_BITS                    = 8;
  localparam int CACHELINE_DATA_WRITE_NUM      = 32;
  localparam int CACHELINE_DATA_WRITE_NUM_HF   = 16;
  localparam int CACHELINE_DATA_WRITE_NUM_BITS = 5;
  localparam int HALF_LINE_BITS                = 512;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    WRITE_NA = 2'd1
  } command_type_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_ISSUE = 2'd1,
    WR_STALL = 2'd2
  } write_state_t;

  typedef struct packed {
    logic                            valid;
    logic [CU_ID_BITS-1:0]           cu_id;
    logic [EDGE_SIZE_BITS-1:0]       index;
    logic [DATA_SIZE_WRITE_BITS-1:0] data;
  } EdgeDataWrite;

  typedef struct packed {
    logic alfull;
  } BufferStatus;

  typedef struct packed {
    logic                                     valid;
    command_type_t                            command;
    logic [63:0]                              address;
    logic [7:0]                               size;
    logic [CU_ID_BITS-1:0]                    cu_id;
    logic [CACHELINE_DATA_WRITE_NUM_BITS-1:0] cacheline_offest;
    logic [63:0]                              address_offest;
  } CommandBufferLine;

  typedef struct packed {
    logic                      valid;
    CommandBufferLine          cmd;
    logic [HALF_LINE_BITS-1:0] data;
  } ReadWriteDataLine;

  function automatic logic [DATA_SIZE_WRITE_BITS-1:0] swap_endianness_data_write(
    input logic [DATA_SIZE_WRITE_BITS-1:0] d
  );
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/cu_edge_data_write_control_fifo.sv
// Synchronous FIFO buffering accepted write elements ahead of the issue FSM.
module fifo_edge_data_write #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cu_edge_data_write_control.sv
// Builds CAPI partial-line write commands and half-line data from CU write elements.
// Optional `CU_WRITE_SWAP_ENDIAN_EN byte-swaps each value before placement.
module cu_edge_data_write_control
  import cu_edge_data_write_control_pkg::*;
#(
  parameter logic [CU_ID_BITS-1:0] CU_ID      = 8'd1,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             enabled_in,
  input  logic [63:0]      array_base_in,
  input  EdgeDataWrite     edge_data_write_in,
  output logic             edge_data_write_ready_out,
  input  BufferStatus      write_buffer_status_in,
  output CommandBufferLine write_command_out,
  output ReadWriteDataLine write_data_0_out,
  output ReadWriteDataLine write_data_1_out,
  output logic [31:0]      write_count_out
);

  localparam int PAYLOAD_W = CU_ID_BITS + EDGE_SIZE_BITS + DATA_SIZE_WRITE_BITS;

  logic                                     enabled_r;
  write_state_t                             state_r, state_s;
  logic                                     push_s, pop_s, fifo_full_s, fifo_empty_s, alfull_s;
  logic [PAYLOAD_W-1:0]                     fifo_rd_data_s;
  logic                                     pop_valid_r, a_valid_r;
  logic [CU_ID_BITS-1:0]                    pop_cu_r, a_cu_r;
  logic [EDGE_SIZE_BITS-1:0]                pop_index_r, a_index_r;
  logic [DATA_SIZE_WRITE_BITS-1:0]          pop_data_r, a_data_r, value_s;
  logic [63:0]                              addr_s, a_addr_r;
  logic [CACHELINE_DATA_WRITE_NUM_BITS-1:0] slot_s, a_slot_r;
  logic [CACHELINE_DATA_WRITE_NUM_BITS-2:0] half_slot_s;
  CommandBufferLine                         cmd_s;
  ReadWriteDataLine                         data0_s, data1_s;
  logic [31:0]                              count_r;

  assign alfull_s                  = write_buffer_status_in.alfull;
  assign edge_data_write_ready_out = enabled_r && !fifo_full_s;
  assign push_s                    = edge_data_write_in.valid && edge_data_write_ready_out;
  assign write_count_out           = count_r;

  fifo_edge_data_write #(.WIDTH(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .rstn      (rstn),
    .push      (push_s),
    .push_data ({edge_data_write_in.cu_id, edge_data_write_in.index, edge_data_write_in.data}),
    .pop       (pop_s),
    .pop_data  (fifo_rd_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Enable and FSM state registers.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      enabled_r <= 1'b0;
      state_r   <= WR_IDLE;
    end else begin
      enabled_r <= enabled_in;
      state_r   <= state_s;
    end
  end

  // Next state and pop; IDLE pops on its way into ISSUE so the first element is not delayed.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    if (enabled_r) begin
      case (state_r)
        WR_IDLE: begin
          if (!fifo_empty_s && !alfull_s) begin
            state_s = WR_ISSUE;
            pop_s   = 1'b1;
          end else begin
            state_s = WR_IDLE;
          end
        end
        WR_ISSUE: begin
          if (alfull_s) begin
            state_s = WR_STALL;
          end else if (fifo_empty_s) begin
            state_s = WR_IDLE;
          end else begin
            state_s = WR_ISSUE;
            pop_s   = 1'b1;
          end
        end
        WR_STALL: begin
          if (!alfull_s) state_s = WR_ISSUE;
          else           state_s = WR_STALL;
        end
        default: state_s = WR_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign addr_s      = array_base_in + ({32'd0, pop_index_r} << DATA_SIZE_WRITE_LOG2);
  assign slot_s      = CACHELINE_DATA_WRITE_NUM_BITS'(addr_s[6:0] >> DATA_SIZE_WRITE_LOG2);
  assign half_slot_s = a_slot_r[CACHELINE_DATA_WRITE_NUM_BITS-2:0];

`ifdef CU_WRITE_SWAP_ENDIAN_EN
  assign value_s = swap_endianness_data_write(a_data_r);
`else
  assign value_s = a_data_r;
`endif

  // Command and half-line assembly from stage A.
  always_comb begin
    cmd_s   = '0;
    data0_s = '0;
    data1_s = '0;
    if (a_valid_r) begin
      cmd_s.valid            = 1'b1;
      cmd_s.command          = WRITE_NA;
      cmd_s.address          = a_addr_r;
      cmd_s.size             = 8'(DATA_SIZE_WRITE);
      cmd_s.cu_id            = (a_cu_r == 8'd0) ? CU_ID : a_cu_r;
      cmd_s.cacheline_offest = a_slot_r;
      cmd_s.address_offest   = {32'd0, a_index_r};
      data0_s.valid          = 1'b1;
      data0_s.cmd            = cmd_s;
      data1_s.valid          = 1'b1;
      data1_s.cmd            = cmd_s;
      if (a_slot_r < 5'(CACHELINE_DATA_WRITE_NUM_HF)) begin
        data0_s.data[int'(half_slot_s)*DATA_SIZE_WRITE_BITS +: DATA_SIZE_WRITE_BITS] = value_s;
      end else begin
        data1_s.data[int'(half_slot_s)*DATA_SIZE_WRITE_BITS +: DATA_SIZE_WRITE_BITS] = value_s;
      end
    end else begin
      cmd_s   = '0;
      data0_s = '0;
      data1_s = '0;
    end
  end

  // Pop stage, stage A and output stage; frozen (outputs cleared) while disabled.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      pop_valid_r       <= 1'b0;
      pop_cu_r          <= '0;
      pop_index_r       <= '0;
      pop_data_r        <= '0;
      a_valid_r         <= 1'b0;
      a_addr_r          <= '0;
      a_slot_r          <= '0;
      a_cu_r            <= '0;
      a_index_r         <= '0;
      a_data_r          <= '0;
      write_command_out <= '0;
      write_data_0_out  <= '0;
      write_data_1_out  <= '0;
      count_r           <= 32'd0;
    end else if (enabled_r) begin
      pop_valid_r                           <= pop_s;
      {pop_cu_r, pop_index_r, pop_data_r}   <= fifo_rd_data_s;
      a_valid_r                             <= pop_valid_r;
      a_addr_r                              <= addr_s;
      a_slot_r                              <= slot_s;
      a_cu_r                                <= pop_cu_r;
      a_index_r                             <= pop_index_r;
      a_data_r                              <= pop_data_r;
      write_command_out                     <= cmd_s;
      write_data_0_out                      <= data0_s;
      write_data_1_out                      <= data1_s;
      if (a_valid_r && (count_r != 32'hFFFF_FFFF)) count_r <= count_r + 32'd1;
    end else begin
      write_command_out <= '0;
      write_data_0_out  <= '0;
      write_data_1_out  <= '0;
    end
  end

endmodule

// File: tb/tb_cu_edge_data_write_control.sv
// Randomized self-checking bench with a queue-based reference model of the write path.
module tb_cu_edge_data_write_control;
  import cu_edge_data_write_control_pkg::*;

  logic             clock = 1'b0;
  logic             rstn;
  logic             enabled_in;
  logic [63:0]      array_base_in;
  EdgeDataWrite     edge_data_write_in;
  logic             edge_data_write_ready_out;
  BufferStatus      write_buffer_status_in;
  CommandBufferLine write_command_out;
  ReadWriteDataLine write_data_0_out;
  ReadWriteDataLine write_data_1_out;
  logic [31:0]      write_count_out;

  always #5 clock = ~clock;

  cu_edge_data_write_control #(.CU_ID(8'd1), .FIFO_DEPTH(8)) dut (
    .clock                     (clock),
    .rstn                      (rstn),
    .enabled_in                (enabled_in),
    .array_base_in             (array_base_in),
    .edge_data_write_in        (edge_data_write_in),
    .edge_data_write_ready_out (edge_data_write_ready_out),
    .write_buffer_status_in    (write_buffer_status_in),
    .write_command_out         (write_command_out),
    .write_data_0_out          (write_data_0_out),
    .write_data_1_out          (write_data_1_out),
    .write_count_out           (write_count_out)
  );

  typedef struct {
    logic [63:0]  addr;
    int unsigned  slot;
    logic [7:0]   cu;
    logic [31:0]  index;
    logic [31:0]  val;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned issued   = 0;
  int          cur_run  = 0;
  int          max_run  = 0;

`ifdef CU_WRITE_SWAP_ENDIAN_EN
  localparam logic [31:0] SINGLE_VAL = 32'hDDCCBBAA;
`else
  localparam logic [31:0] SINGLE_VAL = 32'hAABBCCDD;
`endif

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] base, input logic [7:0] cu,
                                 input logic [31:0] index, input logic [31:0] data);
    exp_t e;
    e.addr  = base + 64'(index) * 64'd4;
    e.slot  = int'(e.addr % 64'd128) / 4;
    e.cu    = (cu == 8'd0) ? 8'd1 : cu;
    e.index = index;
`ifdef CU_WRITE_SWAP_ENDIAN_EN
    e.val   = {data[7:0], data[15:8], data[23:16], data[31:24]};
`else
    e.val   = data;
`endif
    return e;
  endfunction

  // Scoreboard: every valid command must match the oldest accepted element.
  always @(negedge clock) begin
    exp_t e;
    logic [511:0] l0, l1;
    if (!rstn) begin
      issued  = 0;
      cur_run = 0;
    end else if (write_command_out.valid) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (exp_q.size() == 0) begin
        check_val("unexpected_cmd", 512'(write_command_out.address), 512'(0));
      end else begin
        e = exp_q.pop_front();
        issued++;
        l0 = '0;
        l1 = '0;
        if (e.slot < 16) l0 = 512'(e.val) << (e.slot * 32);
        else             l1 = 512'(e.val) << ((e.slot - 16) * 32);
        check_val("cmd_kind",  512'(write_command_out.command), 512'(WRITE_NA));
        check_val("addr",      512'(write_command_out.address), 512'(e.addr));
        check_val("size",      512'(write_command_out.size), 512'(4));
        check_val("slot",      512'(write_command_out.cacheline_offest), 512'(e.slot));
        check_val("aoffs",     512'(write_command_out.address_offest), 512'(e.index));
        check_val("cu_id",     512'(write_command_out.cu_id), 512'(e.cu));
        check_val("d0_valid",  512'(write_data_0_out.valid), 512'(1));
        check_val("d1_valid",  512'(write_data_1_out.valid), 512'(1));
        check_val("d0_addr",   512'(write_data_0_out.cmd.address), 512'(e.addr));
        check_val("d0_data",   write_data_0_out.data, l0);
        check_val("d1_data",   write_data_1_out.data, l1);
        check_val("count",     512'(write_count_out), 512'(issued));
      end
    end else begin
      cur_run = 0;
    end
  end

  task automatic push_item(input logic [7:0] cu, input logic [31:0] index,
                           input logic [31:0] data, input bit rand_bp);
    bit ok = 1'b0;
    bit acc;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (rand_bp) write_buffer_status_in.alfull = ($urandom_range(0, 3) == 0);
      edge_data_write_in = '{valid: 1'b1, cu_id: cu, index: index, data: data};
      acc = edge_data_write_ready_out;
      @(posedge clock);
      if (acc) begin
        ok = 1'b1;
        exp_q.push_back(model(array_base_in, cu, index, data));
      end
      #1;
    end
    edge_data_write_in = '0;
    if (!ok) check_val("push_timeout", 512'(0), 512'(1));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
      #1;
    end
    wait_cycles(4);
    check_val("drain_left", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    rstn                   = 1'b0;
    enabled_in             = 1'b1;
    array_base_in          = 64'h1000;
    edge_data_write_in     = '0;
    write_buffer_status_in = '0;

    // Reset state.
    wait_cycles(3);
    check_val("rst_cmd_valid", 512'(write_command_out.valid), 512'(0));
    check_val("rst_d0_valid",  512'(write_data_0_out.valid), 512'(0));
    check_val("rst_count",     512'(write_count_out), 512'(0));
    check_val("rst_ready",     512'(edge_data_write_ready_out), 512'(0));
    rstn = 1'b1;
    wait_cycles(2);

    // Single write, latency N+3.
    push_item(8'd0, 32'd5, 32'hAABBCCDD, 1'b0);
    wait_cycles(2);
    check_val("lat_n2_valid", 512'(write_command_out.valid), 512'(0));
    wait_cycles(1);
    check_val("lat_n3_valid", 512'(write_command_out.valid), 512'(1));
    check_val("single_addr",  512'(write_command_out.address), 512'(64'h1014));
    check_val("single_slot",  512'(write_command_out.cacheline_offest), 512'(5));
    check_val("single_d0",    write_data_0_out.data, 512'(SINGLE_VAL) << 160);
    check_val("single_d1",    write_data_1_out.data, 512'(0));
    wait_cycles(2);

    // Upper half.
    push_item(8'd3, 32'd20, 32'h12345678, 1'b0);
    wait_cycles(3);
    check_val("upper_addr", 512'(write_command_out.address), 512'(64'h1050));
    check_val("upper_slot", 512'(write_command_out.cacheline_offest), 512'(20));
    check_val("upper_d0",   write_data_0_out.data, 512'(0));
    drain();

    // Back-to-back, slots 0..31.
    max_run = 0;
    for (int i = 0; i < 32; i++) push_item(8'd2, 32'(i), $urandom, 1'b0);
    drain();
    check_val("b2b_run", 512'(max_run), 512'(32));

    // Reset mid-stream with 5 queued.
    write_buffer_status_in.alfull = 1'b1;
    for (int i = 0; i < 5; i++) push_item(8'd0, 32'(100 + i), $urandom, 1'b0);
    rstn = 1'b0;
    exp_q.delete();
    wait_cycles(1);
    check_val("mrst_cmd_valid", 512'(write_command_out.valid), 512'(0));
    check_val("mrst_d1_valid",  512'(write_data_1_out.valid), 512'(0));
    check_val("mrst_count",     512'(write_count_out), 512'(0));
    check_val("mrst_ready",     512'(edge_data_write_ready_out), 512'(0));
    rstn = 1'b1;
    write_buffer_status_in.alfull = 1'b0;
    wait_cycles(10);

    // Back-pressure: FIFO fills at 8 while alfull is held.
    array_base_in = 64'h2000;
    write_buffer_status_in.alfull = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_item(8'd4, 32'(i * 3), $urandom, 1'b0);
      if (i == 6) check_val("bp_ready_7", 512'(edge_data_write_ready_out), 512'(1));
    end
    check_val("bp_ready_8", 512'(edge_data_write_ready_out), 512'(0));
    check_val("bp_no_issue", 512'(write_command_out.valid), 512'(0));
    write_buffer_status_in.alfull = 1'b0;
    for (int i = 8; i < 12; i++) push_item(8'd4, 32'(i * 3), $urandom, 1'b0);
    drain();
    check_val("bp_count", 512'(write_count_out), 512'(12));

    // Disable with 3 queued.
    write_buffer_status_in.alfull = 1'b1;
    for (int i = 0; i < 3; i++) push_item(8'd0, 32'(40 + i), $urandom, 1'b0);
    enabled_in = 1'b0;
    wait_cycles(2);
    write_buffer_status_in.alfull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(1);
      check_val("dis_valid", 512'(write_command_out.valid), 512'(0));
      check_val("dis_ready", 512'(edge_data_write_ready_out), 512'(0));
    end
    enabled_in = 1'b1;
    drain();
    check_val("dis_count", 512'(write_count_out), 512'(15));

    // Randomized traffic with random back-pressure, cu_id and wrapping base.
    array_base_in = {$urandom, $urandom};
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        write_buffer_status_in.alfull = ($urandom_range(0, 3) == 0);
        wait_cycles(1);
      end
      push_item(8'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
    end
    write_buffer_status_in.alfull = 1'b0;
    drain();
    check_val("rand_count", 512'(write_count_out), 512'(165));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
